// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubble, I/D memory freeze, branch flush.
// Define HAZARD_PERF_CNT_EN to add saturating stall/bubble/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              exe_mem_read,
  input  logic [REG_AW-1:0] exe_rd,
  input  logic              exe_br_taken,
  input  logic              imem_req,
  input  logic              imem_resp,
  input  logic              dmem_req,
  input  logic              dmem_resp,
  output logic              load_pc,
  output logic              load_if_id,
  output logic              load_id_exe,
  output logic              load_exe_mem,
  output logic              load_mem_wb,
  output logic              flush_if_id,
  output logic              bubble_id_exe,
  output logic [1:0]        fsm_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_BUB   = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t state, next_state;

  logic mem_wait;
  logic lu_hit;
  logic lu_eff;

  // req/resp: a request stays high until the cycle its resp is high; resp without req is ignored.
  assign mem_wait = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);

  assign lu_hit = exe_mem_read & (exe_rd != '0) &
                  ((id_use_rs1 & (id_rs1 == exe_rd)) | (id_use_rs2 & (id_rs2 == exe_rd)));

  // The cycle after a bubble the load has left EXE; masking here guarantees a single bubble.
  assign lu_eff = lu_hit & (state != LU_BUB);

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // MEM_WAIT with the wait cleared falls through to the RUN decode in the same cycle.
  always_comb begin
    next_state    = RUN;
    load_pc       = 1'b1;
    load_if_id    = 1'b1;
    load_id_exe   = 1'b1;
    load_exe_mem  = 1'b1;
    load_mem_wb   = 1'b1;
    flush_if_id   = 1'b0;
    bubble_id_exe = 1'b0;
    if (rst_n) begin
      if (mem_wait) begin
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_exe  = 1'b0;
        load_exe_mem = 1'b0;
        load_mem_wb  = 1'b0;
        next_state   = MEM_WAIT;
      end else if (exe_br_taken) begin
        flush_if_id   = 1'b1;
        bubble_id_exe = 1'b1;
      end else if (lu_eff) begin
        load_pc       = 1'b0;
        load_if_id    = 1'b0;
        bubble_id_exe = 1'b1;
        next_state    = LU_BUB;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic bubble_ev;

  // A bubble without a flush is a load-use bubble.
  assign bubble_ev = bubble_id_exe & ~flush_if_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (mem_wait && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (bubble_ev && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
      if (flush_if_id && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; counter checks compile in with HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, exe_rd;
  logic       id_use_rs1, id_use_rs2, exe_mem_read, exe_br_taken;
  logic       imem_req, imem_resp, dmem_req, dmem_resp;
  logic       load_pc, load_if_id, load_id_exe, load_exe_mem, load_mem_wb;
  logic       flush_if_id, bubble_id_exe;
  logic [1:0] fsm_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
`endif

  logic [6:0] ctl;
  int checks = 0;
  int errors = 0;

  localparam logic [6:0] RUN_EN = 7'b1111100;
  localparam logic [6:0] STALL  = 7'b0011101;
  localparam logic [6:0] FREEZE = 7'b0000000;
  localparam logic [6:0] FLUSH  = 7'b1111111;
  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_LU   = 2'd1;
  localparam logic [1:0] S_MW   = 2'd2;

  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .exe_mem_read(exe_mem_read), .exe_rd(exe_rd), .exe_br_taken(exe_br_taken),
    .imem_req(imem_req), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_exe(load_id_exe),
    .load_exe_mem(load_exe_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .bubble_id_exe(bubble_id_exe),
    .fsm_state(fsm_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  assign ctl = {load_pc, load_if_id, load_id_exe, load_exe_mem, load_mem_wb,
                flush_if_id, bubble_id_exe};

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; exe_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; exe_mem_read = 1'b0; exe_br_taken = 1'b0;
    imem_req = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    exe_mem_read = 1'b1; exe_rd = rd; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    dmem_req = 1'b1;
    #1;
    checks++; if (ctl !== RUN_EN) begin errors++; $display("FAIL reset_forced_outputs: got %b want %b", ctl, RUN_EN); end
    tick(); tick();
    checks++; if (fsm_state !== S_RUN) begin errors++; $display("FAIL reset_state: got %0d want %0d", fsm_state, S_RUN); end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if ({stall_cnt, bubble_cnt, flush_cnt} !== 96'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", stall_cnt, bubble_cnt, flush_cnt); end
`endif
    clear_inputs();
    rst_n = 1'b1;
    #1;
    checks++; if (ctl !== RUN_EN) begin errors++; $display("FAIL idle_run: got %b want %b", ctl, RUN_EN); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    set_lu(5'd5);
    #1;
    checks++; if (ctl !== STALL) begin errors++; $display("FAIL lu_rs1_stall: got %b want %b", ctl, STALL); end
    tick();
    checks++; if (fsm_state !== S_LU) begin errors++; $display("FAIL lu_state: got %0d want %0d", fsm_state, S_LU); end
    checks++; if (ctl !== RUN_EN) begin errors++; $display("FAIL lu_suppressed: got %b want %b", ctl, RUN_EN); end
    tick();
    checks++; if (fsm_state !== S_RUN) begin errors++; $display("FAIL lu_return: got %0d want %0d", fsm_state, S_RUN); end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if (bubble_cnt !== 32'd1) begin errors++; $display("FAIL lu_bubble_cnt: got %0d want 1", bubble_cnt); end
`endif
    clear_inputs();
    exe_mem_read = 1'b1; exe_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    #1;
    checks++; if (ctl !== STALL) begin errors++; $display("FAIL lu_rs2_stall: got %b want %b", ctl, STALL); end
    tick();
    clear_inputs();
    exe_mem_read = 1'b1; exe_rd = 5'd9; id_rs2 = 5'd9;
    #1;
    checks++; if (ctl !== RUN_EN) begin errors++; $display("FAIL lu_unused_reg: got %b want %b", ctl, RUN_EN); end
    tick();
  endtask

  task automatic test_rd_zero();
    clear_inputs();
    set_lu(5'd0);
    id_rs1 = 5'd0;
    #1;
    checks++; if (ctl !== RUN_EN) begin errors++; $display("FAIL rd_zero: got %b want %b", ctl, RUN_EN); end
    tick();
    checks++; if (fsm_state !== S_RUN) begin errors++; $display("FAIL rd_zero_state: got %0d want %0d", fsm_state, S_RUN); end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if (bubble_cnt !== 32'd2) begin errors++; $display("FAIL rd_zero_bubble_cnt: got %0d want 2", bubble_cnt); end
`endif
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctl !== FREEZE) begin errors++; $display("FAIL dmem_freeze_%0d: got %b want %b", i, ctl, FREEZE); end
      tick();
    end
    checks++; if (fsm_state !== S_MW) begin errors++; $display("FAIL dmem_state: got %0d want %0d", fsm_state, S_MW); end
    dmem_resp = 1'b1;
    #1;
    checks++; if (ctl !== RUN_EN) begin errors++; $display("FAIL dmem_resp_cycle: got %b want %b", ctl, RUN_EN); end
    tick();
    checks++; if (fsm_state !== S_RUN) begin errors++; $display("FAIL dmem_exit: got %0d want %0d", fsm_state, S_RUN); end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL dmem_stall_cnt: got %0d want 4", stall_cnt); end
`endif
    clear_inputs();
    dmem_resp = 1'b1;
    imem_resp = 1'b1;
    #1;
    checks++; if (ctl !== RUN_EN) begin errors++; $display("FAIL resp_no_req: got %b want %b", ctl, RUN_EN); end
    tick();
  endtask

  task automatic test_branch_lu();
    clear_inputs();
    set_lu(5'd5);
    exe_br_taken = 1'b1;
    #1;
    checks++; if (ctl !== FLUSH) begin errors++; $display("FAIL br_over_lu: got %b want %b", ctl, FLUSH); end
    tick();
    checks++; if (fsm_state !== S_RUN) begin errors++; $display("FAIL br_state: got %0d want %0d", fsm_state, S_RUN); end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if (bubble_cnt !== 32'd2) begin errors++; $display("FAIL br_bubble_cnt: got %0d want 2", bubble_cnt); end
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL br_flush_cnt: got %0d want 1", flush_cnt); end
`endif
  endtask

  task automatic test_wait_branch();
    clear_inputs();
    imem_req = 1'b1;
    exe_br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== FREEZE) begin errors++; $display("FAIL imem_br_freeze_%0d: got %b want %b", i, ctl, FREEZE); end
      tick();
    end
    imem_resp = 1'b1;
    #1;
    checks++; if (ctl !== FLUSH) begin errors++; $display("FAIL imem_br_flush: got %b want %b", ctl, FLUSH); end
    tick();
    checks++; if (fsm_state !== S_RUN) begin errors++; $display("FAIL imem_br_exit: got %0d want %0d", fsm_state, S_RUN); end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd7) begin errors++; $display("FAIL imem_stall_cnt: got %0d want 7", stall_cnt); end
    checks++; if (flush_cnt !== 32'd2) begin errors++; $display("FAIL imem_flush_cnt: got %0d want 2", flush_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    dmem_req = 1'b1;
    set_lu(5'd5);
    #1;
    checks++; if (ctl !== FREEZE) begin errors++; $display("FAIL b2b_freeze: got %b want %b", ctl, FREEZE); end
    tick();
    dmem_resp = 1'b1;
    #1;
    checks++; if (ctl !== STALL) begin errors++; $display("FAIL b2b_wait_to_lu: got %b want %b", ctl, STALL); end
    tick();
    checks++; if (fsm_state !== S_LU) begin errors++; $display("FAIL b2b_state: got %0d want %0d", fsm_state, S_LU); end
    clear_inputs();
    tick();
`ifdef HAZARD_PERF_CNT_EN
    checks++; if ({stall_cnt, bubble_cnt} !== {32'd8, 32'd3}) begin errors++; $display("FAIL b2b_counters: got %0d/%0d want 8/3", stall_cnt, bubble_cnt); end
`endif
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    dmem_req = 1'b1;
    tick();
    checks++; if (fsm_state !== S_MW) begin errors++; $display("FAIL mid_rst_pre_state: got %0d want %0d", fsm_state, S_MW); end
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (ctl !== RUN_EN) begin errors++; $display("FAIL mid_rst_outputs: got %b want %b", ctl, RUN_EN); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (fsm_state !== S_RUN) begin errors++; $display("FAIL mid_rst_state: got %0d want %0d", fsm_state, S_RUN); end
    checks++; if (ctl !== RUN_EN) begin errors++; $display("FAIL mid_rst_enables: got %b want %b", ctl, RUN_EN); end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if ({stall_cnt, bubble_cnt, flush_cnt} !== 96'd0) begin errors++; $display("FAIL mid_rst_counters: got %0d/%0d/%0d want 0/0/0", stall_cnt, bubble_cnt, flush_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rd_zero();
    test_mem_wait();
    test_branch_lu();
    test_wait_branch();
    test_back_to_back();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
